spi_master_multi: RTL

- Parametrised successor to the single-byte SPI master.
- Full-duplex SPI master with configurable word width, runtime SCLK divider, runtime CPOL/CPHA mode, MSB/LSB-first ordering and CS_NUM active-low chip selects.
- Sits between a host controller (start/tx_ready/done handshake) and off-chip SPI slaves.
- Configuration is latched per transfer, so the host may change mode or slave between words.

---
 rtl/spi_master_multi_if.sv | 30 +++
 rtl/spi_master_multi.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/spi_master_multi_if.sv
// Host-side handshake and per-transfer configuration bundle for spi_master_multi.
// "slave" is the SPI master block's view, "master" is the host controller's view.
interface spi_master_multi_if #(
    parameter int DATA_W = 8,
    parameter int CS_NUM = 4,
    parameter int DIV_W  = 8
);
    localparam int CS_W = (CS_NUM > 1) ? $clog2(CS_NUM) : 1;

    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [DIV_W-1:0]  clk_div;
    logic [CS_W-1:0]   cs_sel;
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic [DATA_W-1:0] rx_data;
    logic              tx_ready;
    logic              done;

    modport master (
        output cpol, cpha, lsb_first, clk_div, cs_sel, start, tx_data,
        input  rx_data, tx_ready, done
    );

    modport slave (
        input  cpol, cpha, lsb_first, clk_div, cs_sel, start, tx_data,
        output rx_data, tx_ready, done
    );
endinterface

// File: rtl/spi_master_multi.sv
// Full-duplex SPI master: DATA_W-bit words, runtime divider/mode/bit order, CS_NUM selects.
// Define SPI_LOOPBACK_EN to add the loop_en input that feeds MOSI back into the sampler.
module spi_master_multi #(
    parameter int DATA_W = 8,
    parameter int CS_NUM = 4,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    spi_master_multi_if.slave host,
`ifdef SPI_LOOPBACK_EN
    input  logic              loop_en,
`endif
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [CS_NUM-1:0] CS_N
);
    localparam int CS_W   = (CS_NUM > 1) ? $clog2(CS_NUM) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W) + 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_TRANSFER = 3'd2;
    localparam logic [2:0] ST_HOLD     = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    logic [2:0]        state_reg;
    logic [DIV_W-1:0]  div_cnt_reg;
    logic [DIV_W-1:0]  div_lat_reg;
    logic [EDGE_W-1:0] edge_cnt_reg;
    logic              cpol_lat_reg;
    logic              cpha_lat_reg;
    logic              lsb_lat_reg;
    logic [DATA_W-1:0] tx_sh_reg;
    logic [DATA_W-1:0] rx_sh_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic              sclk_reg;
    logic              mosi_reg;
    logic [CS_NUM-1:0] cs_n_reg;

    logic              ready;
    logic              accept;
    logic              period_end;
    logic              leading;
    logic              last_edge;
    logic              sample_in;
    logic              first_bit;
    logic [DATA_W-1:0] tx_init;
    logic              tx_head;
    logic [DATA_W-1:0] tx_shifted;
    logic [DATA_W-1:0] rx_shifted;
    logic [CS_NUM-1:0] cs_dec;

    assign ready      = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign accept     = ready && host.start;
    assign period_end = (div_cnt_reg == div_lat_reg);
    // The edge about to fire is odd-numbered (leading) when the count so far is even.
    assign leading    = ~edge_cnt_reg[0];
    assign last_edge  = (edge_cnt_reg == EDGE_W'(2 * DATA_W - 1));

`ifdef SPI_LOOPBACK_EN
    assign sample_in = loop_en ? mosi_reg : MISO;
`else
    assign sample_in = MISO;
`endif

    // With cpha=0 the first bit goes out during SETUP, so the register starts pre-shifted.
    assign first_bit  = host.lsb_first ? host.tx_data[0] : host.tx_data[DATA_W-1];
    assign tx_init    = host.cpha ? host.tx_data
                      : (host.lsb_first ? (host.tx_data >> 1) : (host.tx_data << 1));
    assign tx_head    = lsb_lat_reg ? tx_sh_reg[0] : tx_sh_reg[DATA_W-1];
    assign tx_shifted = lsb_lat_reg ? (tx_sh_reg >> 1) : (tx_sh_reg << 1);
    assign rx_shifted = lsb_lat_reg ? {sample_in, rx_sh_reg[DATA_W-1:1]}
                                    : {rx_sh_reg[DATA_W-2:0], sample_in};

    // Out-of-range cs_sel matches no index, so every select stays high.
    generate
        for (genvar gi = 0; gi < CS_NUM; gi++) begin : g_cs_dec
            assign cs_dec[gi] = (host.cs_sel != CS_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            div_cnt_reg  <= '0;
            div_lat_reg  <= '0;
            edge_cnt_reg <= '0;
            cpol_lat_reg <= 1'b0;
            cpha_lat_reg <= 1'b0;
            lsb_lat_reg  <= 1'b0;
            tx_sh_reg    <= '0;
            rx_sh_reg    <= '0;
            rx_data_reg  <= '0;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b0;
            cs_n_reg     <= '1;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    sclk_reg <= host.cpol;
                    cs_n_reg <= '1;
                    if (accept) begin
                        cpol_lat_reg <= host.cpol;
                        cpha_lat_reg <= host.cpha;
                        lsb_lat_reg  <= host.lsb_first;
                        div_lat_reg  <= host.clk_div;
                        tx_sh_reg    <= tx_init;
                        mosi_reg     <= first_bit;
                        rx_sh_reg    <= '0;
                        cs_n_reg     <= cs_dec;
                        div_cnt_reg  <= '0;
                        edge_cnt_reg <= '0;
                        state_reg    <= ST_SETUP;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    if (period_end) begin
                        div_cnt_reg <= '0;
                        state_reg   <= ST_TRANSFER;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                ST_TRANSFER: begin
                    if (period_end) begin
                        div_cnt_reg  <= '0;
                        sclk_reg     <= ~sclk_reg;
                        edge_cnt_reg <= edge_cnt_reg + EDGE_W'(1);
                        if (leading != cpha_lat_reg) begin
                            rx_sh_reg <= rx_shifted;
                        end else if (cpha_lat_reg || !last_edge) begin
                            mosi_reg  <= tx_head;
                            tx_sh_reg <= tx_shifted;
                        end
                        if (last_edge) begin
                            state_reg <= ST_HOLD;
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (period_end) begin
                        div_cnt_reg <= '0;
                        cs_n_reg    <= '1;
                        rx_data_reg <= rx_sh_reg;
                        state_reg   <= ST_DONE;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign host.tx_ready = ready;
    assign host.done     = (state_reg == ST_DONE);
    assign host.rx_data  = rx_data_reg;
    assign SCLK          = sclk_reg;
    assign MOSI          = mosi_reg;
    assign CS_N          = cs_n_reg;
endmodule
